// File: rtl/serial_job_link.sv
// Serial job link: a UART framed into fixed-size job words inbound,
// and a result-word FIFO serialised MSB byte first outbound.

module sjl_uart #(
  parameter int CLOCK        = 25000000,
  parameter int BAUD         = 57600,
  parameter int SAMPLE_POINT = 8
) (
  input  logic       clk,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_rx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_busy,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_busy
);

  localparam int OS_RAW = CLOCK / (BAUD * 16);
  localparam int OS_DIV = (OS_RAW > 1) ? OS_RAW : 1;
  localparam int DW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(OS_DIV - 1);
  localparam logic [3:0]    SP       = 4'(SAMPLE_POINT);

  logic [DW-1:0] r_div;
  logic          w_tick;

  // 16x oversampling tick shared by both directions
  always_ff @(posedge clk) begin
    if (r_div == DIV_LAST) r_div <= '0;
    else                   r_div <= r_div + 1'b1;
  end

  assign w_tick = (r_div == DIV_LAST);

  logic       r_rxn1;
  logic       r_rxn2;
  logic       w_rxl;
  logic       r_rx_act;
  logic [3:0] r_rx_os;
  logic [3:0] r_rx_bit;
  logic [7:0] r_rx_sh;
  logic       r_rx_rdy;

  // Line held inverted so power-up zero reads as idle-high
  assign w_rxl = ~r_rxn2;

  always_ff @(posedge clk) begin
    r_rxn1   <= ~i_rx;
    r_rxn2   <= r_rxn1;
    r_rx_rdy <= 1'b0;
    if (!r_rx_act) begin
      if (!w_rxl) begin
        r_rx_act <= 1'b1;
        r_rx_os  <= '0;
        r_rx_bit <= '0;
      end
    end else if (w_tick) begin
      r_rx_os <= r_rx_os + 1'b1;
      if (r_rx_os == SP) begin
        if (r_rx_bit == 4'd0) begin
          if (w_rxl) r_rx_act <= 1'b0;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_act <= 1'b0;
          r_rx_rdy <= w_rxl;
        end else begin
          r_rx_sh <= {w_rxl, r_rx_sh[7:1]};
        end
      end
      if (r_rx_os == 4'd15) r_rx_bit <= r_rx_bit + 1'b1;
    end
  end

  assign o_rx_ready = r_rx_rdy;
  assign o_rx_byte  = r_rx_sh;
  assign o_rx_busy  = r_rx_act;

  logic [9:0] r_tx_sh;
  logic [3:0] r_tx_bit;
  logic [3:0] r_tx_os;

  always_ff @(posedge clk) begin
    if (i_tx_start && r_tx_bit == 4'd0) begin
      r_tx_sh  <= {1'b1, i_tx_byte, 1'b0};
      r_tx_bit <= 4'd10;
      r_tx_os  <= '0;
    end else if (r_tx_bit != 4'd0 && w_tick) begin
      r_tx_os <= r_tx_os + 1'b1;
      if (r_tx_os == 4'd15) begin
        r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
        r_tx_bit <= r_tx_bit - 1'b1;
      end
    end
  end

  assign o_tx      = (r_tx_bit != 4'd0) ? r_tx_sh[0] : 1'b1;
  assign o_tx_busy = (r_tx_bit != 4'd0);

endmodule

module serial_job_link #(
  parameter int CLOCK        = 25000000,
  parameter int BAUD         = 57600,
  parameter int SAMPLE_POINT = 8,
  parameter int JOB_BYTES    = 64,
  parameter int WORD_BYTES   = 4,
  parameter int TX_DEPTH     = 4,
  parameter int RX_TIMEOUT   = 2500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx,
  output logic                    tx,
  output logic                    job_valid,
  output logic [JOB_BYTES*8-1:0]  job_data,
  output logic                    rx_busy,
  output logic                    rx_timeout,
  input  logic [WORD_BYTES*8-1:0] word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    word_drop,
  output logic                    tx_busy
);

  localparam int JW  = JOB_BYTES * 8;
  localparam int SW  = JW - 8;
  localparam int WW  = WORD_BYTES * 8;
  localparam int BCW = $clog2(JOB_BYTES);
  localparam int BW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PW  = $clog2(TX_DEPTH);
  localparam int ICW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam bit TO_EN = (RX_TIMEOUT != 0);

  localparam logic [BCW-1:0] JOB_LAST  = BCW'(JOB_BYTES - 1);
  localparam logic [BW-1:0]  WORD_LAST = BW'(WORD_BYTES - 1);
  localparam logic [PW:0]    DEPTH     = (PW + 1)'(TX_DEPTH);
  localparam logic [ICW-1:0] TO_LAST   =
    ICW'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GUARD,
    S_WAIT
  } state_t;

  logic       w_rx_rdy;
  logic [7:0] w_rx_byte;
  logic       w_urx_busy;
  logic       w_utx_start;
  logic [7:0] w_utx_byte;
  logic       w_utx_busy;

  sjl_uart #(
    .CLOCK        (CLOCK),
    .BAUD         (BAUD),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_uart (
    .clk        (clk),
    .i_rx       (rx),
    .o_tx       (tx),
    .o_rx_ready (w_rx_rdy),
    .o_rx_byte  (w_rx_byte),
    .o_rx_busy  (w_urx_busy),
    .i_tx_start (w_utx_start),
    .i_tx_byte  (w_utx_byte),
    .o_tx_busy  (w_utx_busy)
  );

  logic [SW-1:0]  r_shift;
  logic [JW-1:0]  w_frame;
  logic [JW-1:0]  r_job_data;
  logic           r_job_valid;
  logic           r_rx_timeout;
  logic [BCW-1:0] r_byte_cnt;
  logic [ICW-1:0] r_idle_cnt;

  assign w_frame = {r_shift, w_rx_byte};

  // A byte arriving in the timeout cycle takes priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_job_data   <= '0;
      r_job_valid  <= 1'b0;
      r_rx_timeout <= 1'b0;
      r_byte_cnt   <= '0;
      r_idle_cnt   <= '0;
    end else begin
      r_job_valid  <= 1'b0;
      r_rx_timeout <= 1'b0;
      if (w_rx_rdy) begin
        r_shift    <= w_frame[SW-1:0];
        r_idle_cnt <= '0;
        if (r_byte_cnt == JOB_LAST) begin
          r_job_data  <= w_frame;
          r_byte_cnt  <= '0;
          r_job_valid <= 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end else if (TO_EN && r_byte_cnt != '0) begin
        if (r_idle_cnt == TO_LAST) begin
          r_byte_cnt   <= '0;
          r_idle_cnt   <= '0;
          r_rx_timeout <= 1'b1;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign job_valid  = r_job_valid;
  assign job_data   = r_job_data;
  assign rx_timeout = r_rx_timeout;
  assign rx_busy    = (r_byte_cnt != '0) | w_urx_busy;

  logic [WW-1:0] r_mem [TX_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          r_drop;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full = (r_cnt == DEPTH);
  assign w_push = word_valid & ~w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= word_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= word_valid & w_full;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign word_ready = ~w_full;
  assign word_drop  = r_drop;

  state_t        r_state;
  state_t        w_state_nx;
  logic [WW-1:0] r_sh;
  logic [WW-1:0] w_sh_nx;
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sh    <= w_sh_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  // GUARD gives the uart one cycle to raise busy
  always_comb begin
    w_state_nx  = r_state;
    w_sh_nx     = r_sh;
    w_bcnt_nx   = r_bcnt;
    w_pop       = 1'b0;
    w_utx_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) begin
          w_pop      = 1'b1;
          w_sh_nx    = r_mem[r_rp];
          w_bcnt_nx  = '0;
          w_state_nx = S_SEND;
        end
      end
      S_SEND: begin
        if (!w_utx_busy) begin
          w_utx_start = 1'b1;
          w_sh_nx     = r_sh << 8;
          w_state_nx  = S_GUARD;
        end
      end
      S_GUARD: w_state_nx = S_WAIT;
      S_WAIT: begin
        if (!w_utx_busy) begin
          if (r_bcnt == WORD_LAST) begin
            w_state_nx = S_IDLE;
          end else begin
            w_bcnt_nx  = r_bcnt + 1'b1;
            w_state_nx = S_SEND;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_utx_byte = r_sh[WW-1 -: 8];
  assign tx_busy    = (r_cnt != '0) | (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_job_link.sv
// Bench for serial_job_link: two instances (16-byte jobs with timeout,
// 8-byte jobs without), UART line models and byte/job scoreboards.

module tb_serial_job_link;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int TO_A   = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         rx_a = 1'b1, tx_a;
  logic         job_valid_a, rx_busy_a, rx_timeout_a;
  logic [127:0] job_data_a;
  logic [31:0]  word_in_a = '0;
  logic         word_valid_a = 1'b0;
  logic         word_ready_a, word_drop_a, tx_busy_a;

  logic         rx_b = 1'b1, tx_b;
  logic         job_valid_b, rx_busy_b, rx_timeout_b;
  logic [63:0]  job_data_b;
  logic [15:0]  word_in_b = '0;
  logic         word_valid_b = 1'b0;
  logic         word_ready_b, word_drop_b, tx_busy_b;

  serial_job_link #(
    .CLOCK(CLK_HZ), .BAUD(BAUD), .SAMPLE_POINT(8), .JOB_BYTES(16),
    .WORD_BYTES(4), .TX_DEPTH(4), .RX_TIMEOUT(TO_A)
  ) dut_a (
    .clk(clk), .reset_n(rst_n), .rx(rx_a), .tx(tx_a),
    .job_valid(job_valid_a), .job_data(job_data_a),
    .rx_busy(rx_busy_a), .rx_timeout(rx_timeout_a),
    .word_in(word_in_a), .word_valid(word_valid_a),
    .word_ready(word_ready_a), .word_drop(word_drop_a),
    .tx_busy(tx_busy_a)
  );

  serial_job_link #(
    .CLOCK(CLK_HZ), .BAUD(BAUD), .SAMPLE_POINT(8), .JOB_BYTES(8),
    .WORD_BYTES(2), .TX_DEPTH(4), .RX_TIMEOUT(0)
  ) dut_b (
    .clk(clk), .reset_n(rst_n), .rx(rx_b), .tx(tx_b),
    .job_valid(job_valid_b), .job_data(job_data_b),
    .rx_busy(rx_busy_b), .rx_timeout(rx_timeout_b),
    .word_in(word_in_b), .word_valid(word_valid_b),
    .word_ready(word_ready_b), .word_drop(word_drop_b),
    .tx_busy(tx_busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int got_a = 0, got_b = 0;
  int to_a = 0, to_b = 0;
  logic [7:0]   exp_tx_a[$], exp_tx_b[$];
  logic [127:0] exp_job_a[$], exp_job_b[$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic txl(input int ch);
    return (ch == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic [127:0] pattern(input int n,
      input logic [7:0] first, input logic [7:0] step);
    logic [127:0] v = '0;
    logic [7:0]   b = first;
    for (int i = 0; i < n; i++) begin
      v = {v[119:0], b};
      b = b + step;
    end
    return v;
  endfunction

  task automatic drive_rx(input int ch, input logic v);
    if (ch == 0) rx_a = v;
    else         rx_b = v;
  endtask

  task automatic send_byte(input int ch, input logic [7:0] b);
    drive_rx(ch, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(ch, b[i]);
      repeat (16) @(negedge clk);
    end
    drive_rx(ch, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic send_seq(input int ch, input int n,
      input logic [7:0] first, input logic [7:0] step);
    logic [7:0] b = first;
    for (int i = 0; i < n; i++) begin
      send_byte(ch, b);
      b = b + step;
    end
  endtask

  task automatic mon(input int ch);
    logic [7:0] b;
    logic       s;
    forever begin
      @(negedge clk);
      if (txl(ch) == 1'b0) begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = txl(ch);
        end
        repeat (16) @(negedge clk);
        s = txl(ch);
        if (ch == 0) begin
          got_a++;
          if (exp_tx_a.size() == 0) check("tx_a_extra", 1, 0);
          else check("tx_a_byte", b, exp_tx_a.pop_front());
          check("tx_a_stop", s, 1'b1);
        end else begin
          got_b++;
          if (exp_tx_b.size() == 0) check("tx_b_extra", 1, 0);
          else check("tx_b_byte", b, exp_tx_b.pop_front());
          check("tx_b_stop", s, 1'b1);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  always @(negedge clk) begin
    if (job_valid_a) begin
      if (exp_job_a.size() == 0) check("job_a_extra", 1, 0);
      else check("job_a_data", job_data_a, exp_job_a.pop_front());
    end
    if (job_valid_b) begin
      if (exp_job_b.size() == 0) check("job_b_extra", 1, 0);
      else check("job_b_data", {64'h0, job_data_b}, exp_job_b.pop_front());
    end
    if (rx_timeout_a) to_a++;
    if (rx_timeout_b) to_b++;
  end

  task automatic push_a(input logic [31:0] w, input bit expect_sent);
    word_in_a    = w;
    word_valid_a = 1'b1;
    if (expect_sent)
      for (int k = 3; k >= 0; k--) exp_tx_a.push_back(w[k*8 +: 8]);
    @(negedge clk);
    word_valid_a = 1'b0;
  endtask

  task automatic wait_jobs(input int ch);
    int k = 0;
    while ((ch == 0 ? exp_job_a.size() : exp_job_b.size()) != 0
           && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check(ch == 0 ? "job_wait_a" : "job_wait_b", k < 20000, 1'b1);
  endtask

  task automatic wait_tx(input int ch);
    int k = 0;
    while ((ch == 0 ? tx_busy_a : tx_busy_b) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check(ch == 0 ? "tx_wait_a" : "tx_wait_b", k < 20000, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] last_job;
    int           t0;
    logic [31:0]  w;

    repeat (3) @(negedge clk);
    check("rst_job_valid", job_valid_a, 1'b0);
    check("rst_job_data", job_data_a, '0);
    check("rst_word_ready", word_ready_a, 1'b1);
    check("rst_tx_busy", tx_busy_a, 1'b0);
    check("rst_rx_busy", rx_busy_a, 1'b0);
    check("rst_tx_line", tx_a, 1'b1);
    check("rst_drop", word_drop_a, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // frame 0x00..0x0F
    last_job = pattern(16, 8'h00, 8'h01);
    exp_job_a.push_back(last_job);
    send_seq(0, 16, 8'h00, 8'h01);
    wait_jobs(0);
    repeat (5) @(negedge clk);
    check("f1_msb", job_data_a[127:120], 8'h00);
    check("f1_lsb", job_data_a[7:0], 8'h0F);
    check("f1_rx_busy", rx_busy_a, 1'b0);

    // partial frame then timeout
    t0 = to_a;
    send_seq(0, 5, 8'h55, 8'h11);
    repeat (300) @(negedge clk);
    check("to_early_busy", rx_busy_a, 1'b1);
    check("to_early_cnt", to_a - t0, 0);
    repeat (200) @(negedge clk);
    check("to_cnt", to_a - t0, 1);
    check("to_rx_busy", rx_busy_a, 1'b0);
    check("to_job_held", job_data_a, last_job);
    exp_job_a.push_back(pattern(16, 8'hA5, 8'h00));
    send_seq(0, 16, 8'hA5, 8'h00);
    wait_jobs(0);

    // single word
    t0 = got_a;
    push_a(32'hDEADBEEF, 1'b1);
    wait_tx(0);
    check("w1_bytes_at_idle", got_a - t0, 4);
    check("w1_queue", exp_tx_a.size(), 0);

    // overflow while the serialiser is busy
    t0 = got_a;
    push_a(32'h01020304, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      w = 32'h10203040 + i * 32'h01010101;
      check("ovf_ready", word_ready_a, i < 4);
      word_in_a    = w;
      word_valid_a = 1'b1;
      if (i < 4)
        for (int k = 3; k >= 0; k--) exp_tx_a.push_back(w[k*8 +: 8]);
      @(negedge clk);
    end
    word_valid_a = 1'b0;
    check("ovf_drop", word_drop_a, 1'b1);
    @(negedge clk);
    check("ovf_drop_pulse", word_drop_a, 1'b0);
    wait_tx(0);
    check("ovf_bytes", got_a - t0, 20);
    check("ovf_queue", exp_tx_a.size(), 0);

    // reset mid-frame and mid-word
    send_seq(0, 3, 8'h77, 8'h01);
    t0 = got_a;
    push_a(32'h11223344, 1'b0);
    exp_tx_a.push_back(8'h11);
    repeat (30) @(negedge clk);
    check("pre_rst_rx_busy", rx_busy_a, 1'b1);
    check("pre_rst_tx_busy", tx_busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_job_data", job_data_a, '0);
    check("mid_rst_tx_busy", tx_busy_a, 1'b0);
    check("mid_rst_rx_busy", rx_busy_a, 1'b0);
    check("mid_rst_ready", word_ready_a, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_job_a.push_back(pattern(16, 8'h40, 8'h03));
    send_seq(0, 16, 8'h40, 8'h03);
    wait_jobs(0);
    repeat (400) @(negedge clk);
    check("rst_tx_residual", got_a - t0, 1);
    check("rst_tx_queue", exp_tx_a.size(), 0);

    // small instance without timeout
    exp_job_b.push_back(pattern(8, 8'h80, 8'h01));
    send_seq(1, 8, 8'h80, 8'h01);
    wait_jobs(1);
    send_seq(1, 3, 8'hC0, 8'h01);
    repeat (2000) @(negedge clk);
    check("b_no_timeout", to_b, 0);
    check("b_partial_busy", rx_busy_b, 1'b1);
    exp_job_b.push_back(pattern(8, 8'hC0, 8'h01));
    send_seq(1, 5, 8'hC3, 8'h01);
    wait_jobs(1);
    t0 = got_b;
    exp_tx_b.push_back(8'hBE);
    exp_tx_b.push_back(8'hEF);
    word_in_b    = 16'hBEEF;
    word_valid_b = 1'b1;
    @(negedge clk);
    word_valid_b = 1'b0;
    wait_tx(1);
    check("b_word_bytes", got_b - t0, 2);
    check("b_tx_queue", exp_tx_b.size(), 0);

    repeat (50) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
